// File: rtl/bnn_acc_cfu.sv
// rtl/bnn_acc_cfu.sv - binary neural network XNOR-popcount accumulator custom function unit
package bnn_acc_cfu_pkg;
  typedef enum logic [1:0] {
    CFU_OK        = 2'd0,
    CFU_ERROR_CFU = 2'd1
  } cfu_status_t;
endpackage

module bnn_acc_cfu
  import bnn_acc_cfu_pkg::*;
#(
  parameter int CFU_VERSION    = 100,
  parameter int CFU_CFU_ID_MAX = 1,
  parameter int CFU_CFU_ID_W   = 0,
  parameter int CFU_FUNC_ID_W  = 2,
  parameter int CFU_DATA_W     = 32,
  localparam int CfuW          = (CFU_CFU_ID_W > 0) ? CFU_CFU_ID_W : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CfuW-1:0]          req_cfu,
  input  logic [CFU_FUNC_ID_W-1:0] req_func,
  input  logic [CFU_DATA_W-1:0]    req_data0,
  input  logic [CFU_DATA_W-1:0]    req_data1,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output cfu_status_t              resp_status,
  output logic [CFU_DATA_W-1:0]    resp_data
);

  if (CFU_VERSION < 100) begin : g_bad_version
    $error("bnn_acc_cfu: unsupported CFU_VERSION");
  end
  if (CFU_FUNC_ID_W < 2) begin : g_bad_func_w
    $error("bnn_acc_cfu: CFU_FUNC_ID_W must be at least 2");
  end
  if (CFU_DATA_W != 32 && CFU_DATA_W != 64) begin : g_bad_data_w
    $error("bnn_acc_cfu: CFU_DATA_W must be 32 or 64");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] FN_DOT = 2'd0;
  localparam logic [1:0] FN_MAC = 2'd1;
  localparam logic [1:0] FN_GET = 2'd2;

  state_t                state_q;
  logic [CFU_DATA_W-1:0] x_q;
  logic [CFU_DATA_W-1:0] acc_q;
  logic [CFU_DATA_W-1:0] resp_data_q;
  logic [1:0]            func_q;
  logic                  err_q;
  logic                  resp_valid_q;
  cfu_status_t           resp_status_q;

  logic [CFU_DATA_W-1:0] pop_w;
  logic [CFU_DATA_W-1:0] acc_mac_w;
  logic                  cfu_err_w;
  logic                  unused_func_w;

  always_comb begin
    pop_w = '0;
    for (int i = 0; i < CFU_DATA_W; i++) begin
      pop_w = pop_w + CFU_DATA_W'(x_q[i]);
    end
  end

  assign acc_mac_w     = acc_q + pop_w;
  assign cfu_err_w     = 32'(req_cfu) >= 32'(CFU_CFU_ID_MAX);
  // Only the low two function bits select an operation; the rest are don't-care.
  assign unused_func_w = ^req_func;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      acc_q         <= '0;
      resp_data_q   <= '0;
      func_q        <= '0;
      err_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= CFU_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            x_q     <= ~(req_data0 ^ req_data1);
            func_q  <= req_func[1:0];
            err_q   <= cfu_err_w;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (err_q) begin
            resp_data_q   <= '0;
            resp_status_q <= CFU_ERROR_CFU;
          end else begin
            resp_status_q <= CFU_OK;
            case (func_q)
              FN_DOT: resp_data_q <= pop_w;
              FN_MAC: begin
                acc_q       <= acc_mac_w;
                resp_data_q <= acc_mac_w;
              end
              FN_GET: resp_data_q <= acc_q;
              default: begin
                resp_data_q <= acc_q;
                acc_q       <= '0;
              end
            endcase
          end
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign req_ready   = (state_q == IDLE) && rst_n;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_status = resp_status_q;

endmodule
